data_mem_responder: RTL

//  Memory-side responder for the pipelined CPU's two memory ports. Serves the

---
 rtl/mem_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 68 ++++++
 rtl/data_mem_responder.sv | 78 +++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-side memory responder.
// Entry layout and word-index extraction used by the write buffer and top.
package mem_pkg;

    localparam int DATA_W       = 32;
    localparam int IDX_W        = 30;
    localparam int WB_DEPTH_DEF = 4;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
        logic              valid;
    } wb_entry_t;

    // Word index of a byte address, truncated to w index bits.
    function automatic logic [IDX_W-1:0] word_idx(
        input logic [DATA_W-1:0] addr,
        input int                w
    );
        logic [IDX_W-1:0] mask;
        mask = (IDX_W'(1) << w) - IDX_W'(1);
        return addr[DATA_W-1:2] & mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Posted-store buffer: circular FIFO with a youngest-match lookup port.
// Drain order is oldest first; lookup favours the newest matching entry.
module wb_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enq,
    input  logic [IDX_W-1:0]        enq_idx,
    input  logic [DATA_W-1:0]       enq_data,
    input  logic                    deq,
    input  logic [IDX_W-1:0]        lookup_idx,
    output logic                    hit,
    output logic [DATA_W-1:0]       hit_data,
    output wb_entry_t               head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        ent [DEPTH];
    logic [PTR_W-1:0] hd;
    logic [PTR_W-1:0] tl;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] p;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hd  <= '0;
            tl  <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (deq) begin
                ent[hd].valid <= 1'b0;
                hd            <= hd + PTR_W'(1);
            end
            // Enqueue after dequeue so a full-buffer store may reuse the freed slot.
            if (enq) begin
                ent[tl] <= '{idx: enq_idx, data: enq_data, valid: 1'b1};
                tl      <= tl + PTR_W'(1);
            end
            cnt <= cnt + CNT_W'(enq) - CNT_W'(deq);
        end
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        p        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            p = hd + PTR_W'(k);
            if (ent[p].valid && ent[p].idx == lookup_idx) begin
                hit      = 1'b1;
                hit_data = ent[p].data;
            end
        end
    end

    assign head  = ent[hd];
    assign count = cnt;

endmodule

// File: rtl/data_mem_responder.sv
// Memory responder: instruction ROM fetch port plus data port with a
// posted write buffer that drains whenever no load owns the array port.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_W   = 10,
    parameter int    IROM_W    = 10,
    parameter int    WB_DEPTH  = WB_DEPTH_DEF,
    parameter string IROM_FILE = ""
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          pcF,
    output logic [DATA_W-1:0]          instrF,
    input  logic                       memen,
    input  logic                       memwriteM,
    input  logic [DATA_W-1:0]          aluoutM,
    input  logic [DATA_W-1:0]          writedataM,
    output logic [DATA_W-1:0]          readdataM,
    output logic [$clog2(WB_DEPTH):0]  wb_count,
    output logic                       wb_empty
);

    logic [DATA_W-1:0] rom [2**IROM_W];
    logic [DATA_W-1:0] mem [2**DEPTH_W];

    assign instrF = rom[pcF[IROM_W+1:2]];

    logic             load;
    logic             store;
    logic             drain;
    logic [IDX_W-1:0] idx;
    logic             hit;
    logic [DATA_W-1:0] hit_data;
    wb_entry_t        head;

    assign load  = memen & ~memwriteM;
    assign store = memen & memwriteM;
    assign idx   = word_idx(aluoutM, DEPTH_W);
    // Loads own the single array port; the buffer only drains otherwise.
    assign drain = ~load & ~wb_empty;

    wb_fifo #(
        .DEPTH (WB_DEPTH)
    ) u_wb (
        .clk        (clk),
        .rst        (rst),
        .enq        (store),
        .enq_idx    (idx),
        .enq_data   (writedataM),
        .deq        (drain),
        .lookup_idx (idx),
        .hit        (hit),
        .hit_data   (hit_data),
        .head       (head),
        .count      (wb_count)
    );

    assign wb_empty = (wb_count == '0);

    always_ff @(posedge clk) begin
        if (drain) begin
            mem[head.idx[DEPTH_W-1:0]] <= head.data;
        end
    end

    always_comb begin
        readdataM = '0;
        if (load) begin
            readdataM = hit ? hit_data : mem[idx[DEPTH_W-1:0]];
        end
    end

    logic unused_bits;
    assign unused_bits = ^{pcF[DATA_W-1:IROM_W+2], pcF[1:0],
                           head.idx[IDX_W-1:DEPTH_W], head.valid};

endmodule
